line_fetcher: RTL

LINE_FETCHER -- requirements
Module: line_fetcher

---
 rtl/line_fetcher_if.sv | 33 +++
 rtl/line_fetcher.sv | 130 +++++++++++++
 2 files changed

// File: rtl/line_fetcher_if.sv
// AXI3 read channels (AR + R) between a cache line fetcher (master) and memory (slave).
interface axi3_rd_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/line_fetcher.sv
// Cache line refill engine: one AXI3 read burst per miss, per-beat early-restart stream.
// Optional critical-word-first WRAP bursts when LINE_FETCHER_WRAP_EN is defined.
module line_fetcher #(
   parameter  int LINE_WIDTH       = 256,
   parameter  int ARID             = 0,
   localparam int LINE_BYTE_OFFSET = $clog2(LINE_WIDTH/8),
   localparam int BURST_LIMIT      = LINE_WIDTH/32 - 1,
   localparam int IDX_W            = LINE_BYTE_OFFSET - 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   axi3_rd_if.master             axi_rd,
   input  logic                  req_valid,
   input  logic [31:0]           req_addr,
   output logic                  req_ready,
   output logic                  line_valid,
   output logic [LINE_WIDTH-1:0] line_data,
   output logic [31:0]           line_addr,
   output logic                  word_valid,
   output logic [IDX_W-1:0]      word_idx,
   output logic [31:0]           word_data,
   output logic                  err,
   output logic [1:0]            o_dbg_state
);

   // All handshakes transfer on a rising edge where valid & ready are both high;
   // a valid side holds its payload stable until that edge.
   typedef enum logic [1:0] {LF_IDLE, LF_WAIT_ARREADY, LF_RECV, LF_DONE} lf_state_t;

   lf_state_t             r_state;
   lf_state_t             w_next;
   logic [31:0]           r_addr;
   logic [IDX_W-1:0]      r_cnt;
   logic [IDX_W-1:0]      r_beat;
   logic [LINE_WIDTH-1:0] r_line;
   logic                  r_err;
   logic [IDX_W-1:0]      w_cnt_start;
   logic                  w_beat;
   logic                  w_accept;

`ifdef LINE_FETCHER_WRAP_EN
   assign w_cnt_start    = r_addr[LINE_BYTE_OFFSET-1:2];
   assign axi_rd.araddr  = r_addr & ~32'h3;
   assign axi_rd.arburst = 2'b10;
`else
   assign w_cnt_start    = '0;
   assign axi_rd.araddr  = line_addr;
   assign axi_rd.arburst = 2'b01;
`endif

   assign axi_rd.arid    = 4'(ARID);
   assign axi_rd.arlen   = 4'(BURST_LIMIT);
   assign axi_rd.arsize  = 3'b010;
   assign axi_rd.arlock  = 2'b00;
   assign axi_rd.arcache = 4'b0000;
   assign axi_rd.arprot  = 3'b000;

   assign w_accept    = req_valid & req_ready;
   assign w_beat      = axi_rd.rvalid & axi_rd.rready;
   assign word_valid  = w_beat;
   assign word_idx    = r_cnt;
   assign word_data   = axi_rd.rdata;
   assign line_data   = r_line;
   assign line_addr   = r_addr & ~32'(LINE_WIDTH/8 - 1);
   assign err         = r_err;
   assign o_dbg_state = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= LF_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next         = r_state;
      req_ready      = 1'b0;
      line_valid     = 1'b0;
      axi_rd.arvalid = 1'b0;
      axi_rd.rready  = 1'b0;
      case (r_state)
         LF_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = LF_WAIT_ARREADY;
         end
         LF_WAIT_ARREADY: begin
            axi_rd.arvalid = 1'b1;
            if (axi_rd.arready) w_next = LF_RECV;
         end
         LF_RECV: begin
            axi_rd.rready = 1'b1;
            // Only rlast ends the burst; the beat count alone never does.
            if (axi_rd.rvalid && axi_rd.rlast) w_next = LF_DONE;
         end
         LF_DONE: begin
            line_valid = 1'b1;
            w_next     = LF_IDLE;
         end
         default: w_next = LF_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
         r_cnt  <= '0;
         r_beat <= '0;
         r_line <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr <= req_addr;
            r_err  <= 1'b0;
         end
         if (r_state == LF_WAIT_ARREADY && axi_rd.arready) begin
            r_cnt  <= w_cnt_start;
            r_beat <= '0;
         end
         if (w_beat) begin
            for (int i = 0; i <= BURST_LIMIT; i++) begin
               if (r_cnt == IDX_W'(i)) r_line[i*32 +: 32] <= axi_rd.rdata;
            end
            r_cnt  <= r_cnt + IDX_W'(1);
            r_beat <= r_beat + IDX_W'(1);
            // Beat number is tracked apart from the slot so WRAP bursts judge rlast correctly.
            if (axi_rd.rresp != 2'b00 || (axi_rd.rlast && r_beat != IDX_W'(BURST_LIMIT)))
               r_err <= 1'b1;
         end
      end
   end

endmodule
